bank_cmd_sink: RTL

Consumer end of the bank command stream. Accepts 32-bit bank command words on an Avalon-ST sink, validates them, and applies the 8-bit value to every bank selected by the 4-bit enable mask, one bank per cycle. It then holds off for a settle interval before accepting the next word. It sits downstream of the task parser's bank command source, in front of the physical bank controls, and reports completion, error pulses and a saturating error count.

---
 rtl/cmd_icd_pkg.sv | 43 ++++
 rtl/bank_cmd_sink_if.sv | 20 ++
 rtl/bank_cmd_sink.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cmd_icd_pkg.sv
// Command ICD shared between the task parser and the bank command sink:
// bank command word layout, opcode and pack/unpack helpers.
package cmd_icd_pkg;

    localparam logic [7:0] BANK_CMD_ID = 8'hB5;

    localparam int unsigned BANK_CMD_OP_MSB   = 31;
    localparam int unsigned BANK_CMD_OP_LSB   = 24;
    localparam int unsigned BANK_CMD_RSVD_MSB = 23;
    localparam int unsigned BANK_CMD_RSVD_LSB = 12;
    localparam int unsigned BANK_CMD_MASK_MSB = 11;
    localparam int unsigned BANK_CMD_MASK_LSB = 8;
    localparam int unsigned BANK_CMD_VAL_MSB  = 7;
    localparam int unsigned BANK_CMD_VAL_LSB  = 0;

    localparam int unsigned BANK_NUM = 4;

    typedef struct packed {
        logic [7:0]  op;
        logic [11:0] rsvd;
        logic [3:0]  mask;
        logic [7:0]  val;
    } bank_cmd_t;

    function automatic logic [31:0] task2bank_cmd(input logic [3:0] mask, input logic [7:0] val);
        logic [31:0] word;
        word = '0;
        word[BANK_CMD_OP_MSB:BANK_CMD_OP_LSB]     = BANK_CMD_ID;
        word[BANK_CMD_MASK_MSB:BANK_CMD_MASK_LSB] = mask;
        word[BANK_CMD_VAL_MSB:BANK_CMD_VAL_LSB]   = val;
        return word;
    endfunction

    function automatic bank_cmd_t bank_cmd2fields(input logic [31:0] word);
        bank_cmd_t cmd;
        cmd.op   = word[BANK_CMD_OP_MSB:BANK_CMD_OP_LSB];
        cmd.rsvd = word[BANK_CMD_RSVD_MSB:BANK_CMD_RSVD_LSB];
        cmd.mask = word[BANK_CMD_MASK_MSB:BANK_CMD_MASK_LSB];
        cmd.val  = word[BANK_CMD_VAL_MSB:BANK_CMD_VAL_LSB];
        return cmd;
    endfunction

endpackage

// File: rtl/bank_cmd_sink_if.sv
// Avalon-ST bank command stream: parser side drives master, sink side uses slave.
interface bank_cmd_sink_if;

    logic        asi_cmd_valid;
    logic [31:0] asi_cmd_data;
    logic        asi_cmd_ready;

    modport master (
        output asi_cmd_valid,
        output asi_cmd_data,
        input  asi_cmd_ready
    );

    modport slave (
        input  asi_cmd_valid,
        input  asi_cmd_data,
        output asi_cmd_ready
    );

endinterface

// File: rtl/bank_cmd_sink.sv
// Bank command sink: accepts a command word, validates it, writes the value to each
// enabled bank one per cycle, then waits a settle interval before accepting again.
module bank_cmd_sink
    import cmd_icd_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned ERR_CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bank_cmd_sink_if.slave       cmd,
    output logic [7:0]           bank_val0,
    output logic [7:0]           bank_val1,
    output logic [7:0]           bank_val2,
    output logic [7:0]           bank_val3,
    output logic [3:0]           bank_wr_strb,
    output logic                 cmd_done,
    output logic                 cmd_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, DECODE, APPLY, SETTLE} state_t;

    localparam logic [7:0] SettleLast = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);

    state_t               state_q, state_d;
    bank_cmd_t            cmd_q, cmd_d;
    logic [1:0]           idx_q, idx_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic [7:0]           bank_q [BANK_NUM];
    logic [7:0]           bank_d [BANK_NUM];
    logic [3:0]           strb_q, strb_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        bank_d    = bank_q;
        strb_d    = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            IDLE: begin
                // Ready comes up one edge after reset release, then stays up while idle.
                if (ready_q && cmd.asi_cmd_valid) begin
                    cmd_d   = bank_cmd2fields(cmd.asi_cmd_data);
                    ready_d = 1'b0;
                    state_d = DECODE;
                end else begin
                    ready_d = 1'b1;
                end
            end
            DECODE: begin
                if (cmd_q.op != BANK_CMD_ID || cmd_q.rsvd != '0 || cmd_q.mask == '0) begin
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end else begin
                    idx_d   = 2'd0;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                if (cmd_q.mask[idx_q]) begin
                    bank_d[idx_q] = cmd_q.val;
                    strb_d[idx_q] = 1'b1;
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    if (SETTLE_CYCLES == 0) begin
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SettleLast) begin
                    cnt_d   = 8'd0;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            bank_q    <= '{default: '0};
            strb_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            bank_q    <= bank_d;
            strb_q    <= strb_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign cmd.asi_cmd_ready = ready_q;
    assign bank_val0         = bank_q[0];
    assign bank_val1         = bank_q[1];
    assign bank_val2         = bank_q[2];
    assign bank_val3         = bank_q[3];
    assign bank_wr_strb      = strb_q;
    assign cmd_done          = done_q;
    assign cmd_err           = err_q;
    assign err_cnt           = err_cnt_q;

endmodule
